sram_raster_reader: RTL and testbench

Read-side master for the sram_image frame buffer. On start it walks a W x H window in raster order (x fastest) and issues one synchronous read per pixel on the x/y read port. It returns pixels as a valid/ready stream with coordinate and frame sideband, and feeds the FAST corner pipeline. Backpressure is absorbed by a small credit-tracked output FIFO, so no read is ever dropped or repeated.

---
 rtl/sram_raster_reader_if.sv | 40 ++++
 rtl/sram_raster_reader.sv | 183 ++++++++++++++++++
 tb/tb_sram_raster_reader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_raster_reader_if.sv
// Bundle of the sram_raster_reader control, SRAM read port and pixel stream signals.
// master: the reader; slave: the SRAM plus the stream consumer and controller.
interface sram_raster_reader_if #(
  parameter int unsigned PIXEL_DEPTH = 8,
  parameter int unsigned X_MAX       = 200,
  parameter int unsigned Y_MAX       = 200
);
  localparam int unsigned AW_X = $clog2(X_MAX) + 1;
  localparam int unsigned AW_Y = $clog2(Y_MAX) + 1;

  logic                   start;
  logic [AW_X-1:0]        img_w;
  logic [AW_Y-1:0]        img_h;
  logic                   busy;
  logic                   done;
  logic [AW_X-1:0]        x_addr;
  logic [AW_Y-1:0]        y_addr;
  logic                   ren;
  logic [PIXEL_DEPTH-1:0] rdat;
  logic [PIXEL_DEPTH-1:0] pix_data;
  logic [AW_X-1:0]        pix_x;
  logic [AW_Y-1:0]        pix_y;
  logic                   pix_sof;
  logic                   pix_eol;
  logic                   pix_eof;
  logic                   pix_valid;
  logic                   pix_ready;

  modport master (
    input  start, img_w, img_h, rdat, pix_ready,
    output busy, done, x_addr, y_addr, ren,
           pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof, pix_valid
  );

  modport slave (
    output start, img_w, img_h, rdat, pix_ready,
    input  busy, done, x_addr, y_addr, ren,
           pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof, pix_valid
  );
endinterface

// File: rtl/sram_raster_reader.sv
// Raster-order read master for sram_image with a credit-tracked output FIFO.
// Define SRAM_READ_LAT2_EN for a registered-output SRAM (READ_LAT = 2, DEPTH = 3).
module sram_raster_reader #(
  parameter int unsigned PIXEL_DEPTH = 8,
  parameter int unsigned X_MAX       = 200,
  parameter int unsigned Y_MAX       = 200
) (
  input  logic                 clk,
  input  logic                 n_rst,
  sram_raster_reader_if.master bus
);
  localparam int unsigned AW_X = $clog2(X_MAX) + 1;
  localparam int unsigned AW_Y = $clog2(Y_MAX) + 1;
`ifdef SRAM_READ_LAT2_EN
  localparam int unsigned READ_LAT = 2;
  localparam int unsigned DEPTH    = 3;
`else
  localparam int unsigned READ_LAT = 1;
  localparam int unsigned DEPTH    = 2;
`endif
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic            vld;
    logic [AW_X-1:0] x;
    logic [AW_Y-1:0] y;
    logic            sof;
    logic            eol;
    logic            eof;
  } tag_t;

  typedef struct packed {
    logic [PIXEL_DEPTH-1:0] data;
    logic [AW_X-1:0]        x;
    logic [AW_Y-1:0]        y;
    logic                   sof;
    logic                   eol;
    logic                   eof;
  } pix_t;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_e;

  state_e          state_q, state_d;
  logic [AW_X-1:0] w_q, w_d, x_q, x_d;
  logic [AW_Y-1:0] h_q, h_d, y_q, y_d;
  tag_t            pipe_q [READ_LAT];
  pix_t            fifo_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_idx;
  logic [CW-1:0]   count_q, inflight;
  logic [CW:0]     occ, wsum;
  logic [AW_X-1:0] w_clamp;
  logic [AW_Y-1:0] h_clamp;
  logic            push, pop, issue, x_last, y_last, drain_done;
  tag_t            tag_in;
  pix_t            head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) inflight = inflight + CW'(pipe_q[i].vld);
  end

  assign pop  = (count_q != '0) && bus.pix_ready;
  assign push = pipe_q[READ_LAT-1].vld;
  // A pop this cycle frees its slot immediately, which keeps one pixel per cycle.
  assign occ  = (CW+1)'(count_q) + (CW+1)'(inflight) - (CW+1)'(pop);

  assign issue  = (state_q == StIssue) && (occ < (CW+1)'(DEPTH));
  assign x_last = (x_q == w_q - 1'b1);
  assign y_last = (y_q == h_q - 1'b1);

  assign w_clamp = (bus.img_w > AW_X'(X_MAX)) ? AW_X'(X_MAX) : bus.img_w;
  assign h_clamp = (bus.img_h > AW_Y'(Y_MAX)) ? AW_Y'(Y_MAX) : bus.img_h;

  assign drain_done = (inflight == '0) &&
                      ((count_q == '0) || ((count_q == CW'(1)) && pop));

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          w_d     = w_clamp;
          h_d     = h_clamp;
          x_d     = '0;
          y_d     = '0;
          state_d = ((w_clamp == '0) || (h_clamp == '0)) ? StFin : StIssue;
        end
      end
      StIssue: begin
        if (issue) begin
          if (x_last && y_last) begin
            state_d = StDrain;
          end else if (x_last) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      StDrain: if (drain_done) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tag_in     = '0;
    tag_in.vld = issue;
    tag_in.x   = x_q;
    tag_in.y   = y_q;
    tag_in.sof = (x_q == '0) && (y_q == '0);
    tag_in.eol = x_last;
    tag_in.eof = x_last && y_last;
  end

  always_comb begin
    wsum   = (CW+1)'(rd_ptr_q) + (CW+1)'(count_q);
    wr_idx = (wsum >= (CW+1)'(DEPTH)) ? PW'(wsum - (CW+1)'(DEPTH)) : PW'(wsum);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Coordinate and sideband travel alongside the read so they meet rdat at capture.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_idx] <= '{data: bus.rdat, x: pipe_q[READ_LAT-1].x, y: pipe_q[READ_LAT-1].y,
                            sof: pipe_q[READ_LAT-1].sof, eol: pipe_q[READ_LAT-1].eol,
                            eof: pipe_q[READ_LAT-1].eof};
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign head = fifo_q[rd_ptr_q];

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StFin);
  assign bus.ren       = issue;
  assign bus.x_addr    = x_q;
  assign bus.y_addr    = y_q;
  assign bus.pix_valid = (count_q != '0);
  assign bus.pix_data  = head.data;
  assign bus.pix_x     = head.x;
  assign bus.pix_y     = head.y;
  assign bus.pix_sof   = head.sof;
  assign bus.pix_eol   = head.eol;
  assign bus.pix_eof   = head.eof;
endmodule

// File: tb/tb_sram_raster_reader.sv
// Directed bench for sram_raster_reader: SRAM model returns a coordinate hash per pixel.
// Honours SRAM_READ_LAT2_EN to match the reader's latency and FIFO depth.
module tb_sram_raster_reader;
  localparam int AW = 9;
`ifdef SRAM_READ_LAT2_EN
  localparam int LAT   = 2;
  localparam int DEPTH = 3;
`else
  localparam int LAT   = 1;
  localparam int DEPTH = 2;
`endif

  logic clk;
  logic n_rst;

  sram_raster_reader_if #(.PIXEL_DEPTH(8), .X_MAX(200), .Y_MAX(200)) bus ();

  sram_raster_reader #(.PIXEL_DEPTH(8), .X_MAX(200), .Y_MAX(200)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix_fn(input logic [AW-1:0] x, input logic [AW-1:0] y);
    return 8'((int'(x) * 3 + int'(y) * 17 + 90) & 255);
  endfunction

  logic [7:0] rd1, rd2;
  always @(posedge clk) begin
    if (bus.ren) rd1 <= pix_fn(bus.x_addr, bus.y_addr);
    rd2 <= rd1;
  end
`ifdef SRAM_READ_LAT2_EN
  assign bus.rdat = rd2;
`else
  assign bus.rdat = rd1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int s_pix, s_bad, s_sof, s_eol, s_eof, s_done, s_done_at, s_done_gap, s_first, s_first_hs;
  int s_last_hs, s_stall_bad, s_credit_bad, s_ren, s_maxx, s_maxy, s_busy, s_timeout;
  logic [15:0] lfsr = 16'hACE1;

  task automatic do_start(input int w, input int h);
    @(negedge clk);
    bus.img_w = AW'(w);
    bus.img_h = AW'(h);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Sample n sits just after the n-th rising edge following the edge that accepted start.
  task automatic collect(input int w, input int h, input bit rnd, input int abort_at,
                         input int inject_at, input int budget);
    int ex, ey, occ, hs, post;
    bit injected, aborted, p_stall;
    logic [7:0] p_data;
    logic [AW-1:0] p_x, p_y;
    s_pix = 0; s_bad = 0; s_sof = 0; s_eol = 0; s_eof = 0; s_done = 0; s_done_at = -1;
    s_done_gap = -1; s_first = -1; s_first_hs = -1; s_last_hs = -1; s_stall_bad = 0;
    s_credit_bad = 0; s_ren = 0; s_maxx = 0; s_maxy = 0; s_busy = 0; s_timeout = 0;
    ex = 0; ey = 0; occ = 0; post = 0; injected = 0; aborted = 0; p_stall = 0;
    p_data = '0; p_x = '0; p_y = '0;
    for (int n = 0; n < budget; n++) begin
      if (rnd) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        bus.pix_ready = lfsr[0];
      end else begin
        bus.pix_ready = 1'b1;
      end
      if (inject_at >= 0 && s_pix == inject_at && !injected) begin
        bus.start = 1'b1; bus.img_w = 9'd3; bus.img_h = 9'd3; injected = 1;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      if (bus.busy) s_busy++;
      if (p_stall && ({bus.pix_data, bus.pix_x, bus.pix_y} !== {p_data, p_x, p_y})) s_stall_bad++;
      hs = int'(bus.pix_valid && bus.pix_ready);
      if (occ > DEPTH) s_credit_bad++;
      if (bus.ren && (occ - hs >= DEPTH)) s_credit_bad++;
      if (bus.ren) begin
        s_ren++;
        if (int'(bus.x_addr) > s_maxx) s_maxx = int'(bus.x_addr);
        if (int'(bus.y_addr) > s_maxy) s_maxy = int'(bus.y_addr);
      end
      if (bus.pix_valid && s_first < 0) s_first = n;
      if (hs != 0) begin
        if (bus.pix_data !== pix_fn(AW'(ex), AW'(ey)) || bus.pix_x !== AW'(ex) ||
            bus.pix_y !== AW'(ey) || bus.pix_sof !== (ex == 0 && ey == 0) ||
            bus.pix_eol !== (ex == w - 1) || bus.pix_eof !== (ex == w - 1 && ey == h - 1))
          s_bad++;
        if (bus.pix_sof) s_sof++;
        if (bus.pix_eol) s_eol++;
        if (bus.pix_eof) s_eof++;
        if (s_first_hs < 0) s_first_hs = n;
        s_last_hs = n;
        s_pix++;
        if (ex == w - 1) begin ex = 0; ey++; end else ex++;
      end
      if (bus.done) begin
        s_done++;
        if (s_done == 1) begin s_done_at = n; s_done_gap = n - s_last_hs; post = 4; end
      end else if (post > 0) begin
        post--;
        if (post == 0) break;
      end
      occ = occ + int'(bus.ren) - hs;
      p_stall = bus.pix_valid && !bus.pix_ready;
      p_data = bus.pix_data; p_x = bus.pix_x; p_y = bus.pix_y;
      if (abort_at >= 0 && s_pix == abort_at) begin aborted = 1; break; end
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (s_done == 0 && !aborted) s_timeout = 1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; bus.start = 1'b0; bus.img_w = '0; bus.img_h = '0; bus.pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.ren, bus.pix_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000",
                         {bus.busy, bus.done, bus.ren, bus.pix_valid});
    end
    n_checks++;
    if ({bus.x_addr, bus.y_addr, bus.pix_data, bus.pix_x, bus.pix_y} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0",
                         {bus.x_addr, bus.y_addr, bus.pix_data, bus.pix_x, bus.pix_y});
    end
    n_rst = 1'b1;
  endtask

  task automatic test_full_frame();
    do_start(16, 16);
    collect(16, 16, 0, -1, -1, 1000);
    n_checks++; if (s_pix !== 256) begin n_fail++; $display("FAIL full_count: got %0d expected 256", s_pix); end
    n_checks++; if (s_bad !== 0) begin n_fail++; $display("FAIL full_pixels: got %0d bad expected 0", s_bad); end
    n_checks++; if (s_first !== LAT + 1) begin n_fail++; $display("FAIL full_latency: got %0d expected %0d", s_first, LAT + 1); end
    n_checks++; if (s_last_hs - s_first_hs !== 255) begin n_fail++; $display("FAIL full_rate: got %0d expected 255", s_last_hs - s_first_hs); end
    n_checks++; if (s_sof !== 1 || s_eof !== 1) begin n_fail++; $display("FAIL full_sof_eof: got %0d/%0d expected 1/1", s_sof, s_eof); end
    n_checks++; if (s_eol !== 16) begin n_fail++; $display("FAIL full_eol: got %0d expected 16", s_eol); end
    n_checks++; if (s_done !== 1 || s_done_gap !== 1) begin n_fail++; $display("FAIL full_done: got %0d gap %0d expected 1 gap 1", s_done, s_done_gap); end
  endtask

  task automatic test_backpressure();
    do_start(5, 5);
    collect(5, 5, 1, -1, -1, 2000);
    n_checks++; if (s_pix !== 25 || s_ren !== 25) begin n_fail++; $display("FAIL bp_count: got %0d pix %0d ren expected 25", s_pix, s_ren); end
    n_checks++; if (s_bad !== 0) begin n_fail++; $display("FAIL bp_pixels: got %0d bad expected 0", s_bad); end
    n_checks++; if (s_stall_bad !== 0) begin n_fail++; $display("FAIL bp_stall_hold: got %0d expected 0", s_stall_bad); end
    n_checks++; if (s_credit_bad !== 0) begin n_fail++; $display("FAIL bp_credit: got %0d expected 0", s_credit_bad); end
    n_checks++; if (s_done !== 1 || s_timeout !== 0) begin n_fail++; $display("FAIL bp_done: got %0d timeout %0d expected 1", s_done, s_timeout); end
  endtask

  task automatic test_zero_dim();
    do_start(0, 7);
    collect(1, 7, 0, -1, -1, 50);
    n_checks++; if (s_ren !== 0 || s_pix !== 0) begin n_fail++; $display("FAIL zero_reads: got %0d ren %0d pix expected 0", s_ren, s_pix); end
    n_checks++; if (s_done !== 1 || s_done_at !== 0) begin n_fail++; $display("FAIL zero_done: got %0d at %0d expected 1 at 0", s_done, s_done_at); end
    n_checks++; if (s_busy !== 1) begin n_fail++; $display("FAIL zero_busy: got %0d cycles expected 1", s_busy); end
  endtask

  task automatic test_clamp();
    do_start(255, 254);
    collect(200, 200, 0, -1, -1, 41000);
    n_checks++; if (s_pix !== 40000 || s_bad !== 0) begin n_fail++; $display("FAIL clamp_pixels: got %0d pix %0d bad expected 40000/0", s_pix, s_bad); end
    n_checks++; if (s_maxx !== 199 || s_maxy !== 199) begin n_fail++; $display("FAIL clamp_addr: got %0d,%0d expected 199,199", s_maxx, s_maxy); end
    n_checks++; if (s_eof !== 1 || s_done !== 1) begin n_fail++; $display("FAIL clamp_end: got eof %0d done %0d expected 1/1", s_eof, s_done); end
  endtask

  task automatic test_start_ignored();
    do_start(16, 16);
    collect(16, 16, 0, -1, 10, 1000);
    n_checks++; if (s_pix !== 256 || s_bad !== 0) begin n_fail++; $display("FAIL restart_pixels: got %0d pix %0d bad expected 256/0", s_pix, s_bad); end
    n_checks++; if (s_done !== 1) begin n_fail++; $display("FAIL restart_done: got %0d expected 1", s_done); end
  endtask

  task automatic test_reset_midframe();
    do_start(16, 16);
    collect(16, 16, 0, 100, -1, 1000);
    n_checks++; if (s_pix !== 100) begin n_fail++; $display("FAIL abort_reach: got %0d expected 100", s_pix); end
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.ren, bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_eof} !== 7'b0) begin
      n_fail++; $display("FAIL abort_ctrl: got %b expected 0000000",
        {bus.busy, bus.done, bus.ren, bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_eof});
    end
    n_checks++;
    if ({bus.x_addr, bus.y_addr, bus.pix_data, bus.pix_x, bus.pix_y} !== '0) begin
      n_fail++; $display("FAIL abort_data: got %h expected 0",
                         {bus.x_addr, bus.y_addr, bus.pix_data, bus.pix_x, bus.pix_y});
    end
    @(negedge clk);
    n_rst = 1'b1;
    do_start(4, 4);
    collect(4, 4, 0, -1, -1, 200);
    n_checks++; if (s_pix !== 16 || s_bad !== 0) begin n_fail++; $display("FAIL abort_restart: got %0d pix %0d bad expected 16/0", s_pix, s_bad); end
    n_checks++; if (s_done !== 1) begin n_fail++; $display("FAIL abort_done: got %0d expected 1", s_done); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_zero_dim();
    test_clamp();
    test_start_ignored();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
